// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts one command
// byte out on device clock falls and checks the device acknowledge.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] command,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned CntMax =
        (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StShift,
        StAck,
        StWaitIdle,
        StDone,
        StFail
    } state_e;

    state_e          state;
    logic            clk_low;
    logic            dat_low;
    logic            clk_s1;
    logic            clk_s2;
    logic            clk_prev;
    logic            dat_s1;
    logic            dat_s2;
    logic            fall;
    logic            timeout;
    logic [9:0]      frame;
    logic [3:0]      bit_cnt;
    logic [CntW-1:0] cnt;

    // Open-drain pads: only ever pull low, the bus pull-ups provide the high level.
    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

    assign fall    = clk_prev & ~clk_s2;
    assign timeout = (cnt == CntW'(TIMEOUT_CYCLES - 1));

    // Synchronizers reset to the idle-high bus level so no false fall follows reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= PS2_CLK;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= PS2_DAT;
            dat_s2   <= dat_s1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= StIdle;
            clk_low <= 1'b0;
            dat_low <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            frame   <= '0;
            bit_cnt <= '0;
            cnt     <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (send) begin
                        frame   <= {1'b1, ~^command, command};
                        bit_cnt <= '0;
                        cnt     <= '0;
                        clk_low <= 1'b1;
                        busy    <= 1'b1;
                        state   <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (cnt == CntW'(INHIBIT_CYCLES - 1)) begin
                        cnt     <= '0;
                        dat_low <= 1'b1;
                        state   <= StRts;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StRts: begin
                    clk_low <= 1'b0;
                    cnt     <= '0;
                    state   <= StShift;
                end
                StShift, StAck, StWaitIdle: begin
                    cnt <= fall ? '0 : cnt + 1'b1;
                    if (!fall && timeout) begin
                        dat_low <= 1'b0;
                        error   <= 1'b1;
                        state   <= StFail;
                    end else if (state == StShift) begin
                        if (fall) begin
                            dat_low <= ~frame[0];
                            frame   <= {1'b0, frame[9:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd9) begin
                                state <= StAck;
                            end
                        end
                    end else if (state == StAck) begin
                        if (fall) begin
                            if (dat_s2) begin
                                dat_low <= 1'b0;
                                error   <= 1'b1;
                                state   <= StFail;
                            end else begin
                                state <= StWaitIdle;
                            end
                        end
                    end else if (clk_s2 && dat_s2) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone, StFail: begin
                    clk_low <= 1'b0;
                    dat_low <= 1'b0;
                    busy    <= 1'b0;
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a pulled-up bus with a simple keyboard model that clocks
// the frame in, optionally acknowledges, and checks outputs against hand-computed values.
module tb_ps2_host_tx;

    localparam int unsigned INHIBIT = 20;
    localparam int unsigned TIMEOUT = 200;

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       send        = 1'b0;
    logic [7:0] command     = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       busy;
    logic       done;
    logic       error;
    wire        ps2_clk;
    wire        ps2_dat;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    pullup pu_clk (ps2_clk);
    pullup pu_dat (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLOCK_50(clock),
        .reset   (reset),
        .send    (send),
        .command (command),
        .PS2_CLK (ps2_clk),
        .PS2_DAT (ps2_dat),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #10 clock = ~clock;

    always @(posedge clock) begin
        if (done) done_cnt <= done_cnt + 1;
        if (error) err_cnt <= err_cnt + 1;
        if (done && error) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c);
        @(negedge clock);
        command = c;
        send    = 1'b1;
        @(negedge clock);
        send    = 1'b0;
    endtask

    // Entered on the first INHIBIT cycle; leaves on the first SHIFT cycle.
    task automatic host_start(input string tag);
        int n = 0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (ps2_clk === 1'b0 && ps2_dat === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        check({tag, "_inhibit_len"}, n, INHIBIT);
        check({tag, "_rts_clk"}, 32'(ps2_clk), 32'd0);
        check({tag, "_rts_dat"}, 32'(ps2_dat), 32'd0);
        @(negedge clock);
        check({tag, "_clk_released"}, 32'(ps2_clk), 32'd1);
        check({tag, "_start_bit"}, 32'(ps2_dat), 32'd0);
    endtask

    // Keyboard model: 16-cycle clock period, samples each bit late in the low phase.
    task automatic dev_frame(input bit give_ack, input int poke_at, input int stop_at,
                             output logic [9:0] bits);
        bits = '0;
        repeat (4) @(negedge clock);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (4) @(negedge clock);
            if (i == poke_at) begin
                command = 8'h00;
                send    = 1'b1;
            end
            @(negedge clock);
            send = 1'b0;
            repeat (3) @(negedge clock);
            bits[i-1]   = ps2_dat;
            dev_clk_low = 1'b0;
            if (i == stop_at) return;
            repeat (8) @(negedge clock);
        end
        if (give_ack) dev_dat_low = 1'b1;
        repeat (2) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (8) @(negedge clock);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && !error && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_no_error"}, 32'(error), 32'd0);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        @(negedge clock);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [9:0] bits;
        int         d0;
        int         e0;
        int         n;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_clk", 32'(ps2_clk), 32'd1);
        check("reset_dat", 32'(ps2_dat), 32'd1);

        // 0xED: bits 1,0,1,1,0,1,1,1, odd parity 1, stop 1.
        d0 = done_cnt;
        e0 = err_cnt;
        send_cmd(8'hED);
        host_start("ed");
        dev_frame(1'b1, 0, 0, bits);
        check("ed_frame", 32'(bits), 32'h3ED);
        wait_done("ed");
        repeat (4) @(negedge clock);
        check("ed_done_count", done_cnt - d0, 1);
        check("ed_error_count", err_cnt - e0, 0);

        // 0xF4 without acknowledge: bits 0,0,1,0,1,1,1,1, parity 0.
        d0 = done_cnt;
        e0 = err_cnt;
        send_cmd(8'hF4);
        host_start("f4");
        dev_frame(1'b0, 0, 0, bits);
        check("f4_frame", 32'(bits), 32'h2F4);
        repeat (10) @(negedge clock);
        check("f4_error_count", err_cnt - e0, 1);
        check("f4_done_count", done_cnt - d0, 0);
        check("f4_busy", 32'(busy), 32'd0);
        check("f4_clk_released", 32'(ps2_clk), 32'd1);
        check("f4_dat_released", 32'(ps2_dat), 32'd1);

        // Silent device: 200 SHIFT cycles without a fall, error on the next one.
        d0 = done_cnt;
        e0 = err_cnt;
        send_cmd(8'hFF);
        host_start("ff");
        n = 1;
        while (!error && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("timeout_latency", n, TIMEOUT + 1);
        check("timeout_busy_in_fail", 32'(busy), 32'd1);
        @(negedge clock);
        check("timeout_busy_after", 32'(busy), 32'd0);
        check("timeout_clk_released", 32'(ps2_clk), 32'd1);
        check("timeout_dat_released", 32'(ps2_dat), 32'd1);
        check("timeout_error_count", err_cnt - e0, 1);
        check("timeout_done_count", done_cnt - d0, 0);

        // A send of 0x00 mid-frame must not disturb the 0xED transfer.
        d0 = done_cnt;
        e0 = err_cnt;
        send_cmd(8'hED);
        host_start("ign");
        dev_frame(1'b1, 3, 0, bits);
        check("ign_frame", 32'(bits), 32'h3ED);
        wait_done("ign");
        repeat (40) @(negedge clock);
        check("ign_done_count", done_cnt - d0, 1);
        check("ign_error_count", err_cnt - e0, 0);
        check("ign_idle_busy", 32'(busy), 32'd0);
        check("ign_idle_clk", 32'(ps2_clk), 32'd1);

        // Reset after edge 5; bit 4 of 0xED is 0 so the host is pulling data low here.
        d0 = done_cnt;
        e0 = err_cnt;
        send_cmd(8'hED);
        host_start("rst");
        dev_frame(1'b1, 0, 5, bits);
        check("rst_partial_bits", 32'(bits[4:0]), 32'h0D);
        check("rst_dat_before", 32'(ps2_dat), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clk_released", 32'(ps2_clk), 32'd1);
        check("rst_dat_released", 32'(ps2_dat), 32'd1);
        repeat (10) @(negedge clock);
        check("rst_done_count", done_cnt - d0, 0);
        check("rst_error_count", err_cnt - e0, 0);

        send_cmd(8'hED);
        host_start("post");
        dev_frame(1'b1, 0, 0, bits);
        check("post_frame", 32'(bits), 32'h3ED);
        wait_done("post");
        repeat (4) @(negedge clock);
        check("post_done_count", done_cnt - d0, 1);
        check("post_error_count", err_cnt - e0, 0);

        check("done_error_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
